// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus: one outstanding request, ack-accepted,
// with a single rvalid-qualified response word per accepted request.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 64
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch front end: single-outstanding imem requester, DEPTH-entry instruction FIFO,
// branch redirect with response draining. Optional opcode legality check: FETCH_OPCODE_CHECK_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  instr_fetch_unit_if.master   imem,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [31:0]          inst,
  output logic [ADDR_W-1:0]    inst_pc,
  output logic [10:0]          Opcode,
  output logic                 illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0]  req_pc_reg;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_after;

  logic [31:0]        inst_mem_reg [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_reg   [DEPTH];
  logic [DEPTH-1:0]   we;

  logic               req;
  logic               accept;
  logic               rsp;
  logic               push;
  logic               pop;

  assign accept = (state_reg == REQ) && imem.imem_ack;
  // Responses only matter while a request is known to be outstanding.
  assign rsp    = ((state_reg == WAIT) || (state_reg == DRAIN)) && imem.imem_rvalid;
  assign push   = (state_reg == WAIT) && imem.imem_rvalid && !redirect;
  assign pop    = inst_valid && inst_ready;

  assign count_after = count_reg + CNT_W'(push) - CNT_W'(pop);

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc_reg;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req           = 1'b0;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        req = 1'b1;
        if (accept) begin
          fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (rsp) begin
          state_next = (count_after < CNT_W'(DEPTH)) ? REQ : HOLD;
        end
      end
      HOLD: begin
        if (count_reg < CNT_W'(DEPTH)) begin
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (rsp) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

    // A response landing in the redirect cycle closes the outstanding request,
    // so draining is only needed when one is still in flight afterwards.
    if (redirect) begin
      fetch_pc_next = redirect_pc;
      if (accept ||
          (((state_reg == WAIT) || (state_reg == DRAIN)) && !imem.imem_rvalid)) begin
        state_next = DRAIN;
      end else begin
        state_next = REQ;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (accept) begin
        req_pc_reg <= fetch_pc_reg;
      end
      if (redirect) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_after;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Entries are cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_reg[i] <= '0;
        pc_mem_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) begin
          inst_mem_reg[i] <= imem.imem_rdata;
          pc_mem_reg[i]   <= req_pc_reg;
        end
      end
    end
  end

  assign inst_valid = (count_reg != '0);
  assign inst       = inst_mem_reg[rd_ptr_reg];
  assign inst_pc    = pc_mem_reg[rd_ptr_reg];
  assign Opcode     = inst[31:21];

`ifdef FETCH_OPCODE_CHECK_EN
  logic [DEPTH-1:0] ill_mem_reg;

  function automatic logic opcode_illegal(input logic [10:0] op);
    logic legal;
    legal = (op == 11'b11111000010) ||   // LDUR
            (op == 11'b11111000000) ||   // STUR
            (op == 11'b10001011000) ||   // ADD
            (op == 11'b11001011000) ||   // SUB
            (op == 11'b10001010000) ||   // AND
            (op == 11'b10101010000) ||   // ORR
            (op[10:3] == 8'b10110100) || // CBZ
            (op[10:5] == 6'b000101);     // B
    return !legal;
  endfunction

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ill_mem_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) begin
          ill_mem_reg[i] <= opcode_illegal(imem.imem_rdata[31:21]);
        end
      end
    end
  end

  assign illegal = ill_mem_reg[rd_ptr_reg] & inst_valid;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: transaction-level stream model (expected PC sequence,
// address-derived memory contents, one-outstanding memory responder) plus directed scenarios.
module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 64;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [10:0] Opcode;
  logic        illegal;

  always #5 CLK = ~CLK;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) imem ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .imem        (imem),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .Opcode      (Opcode),
    .illegal     (illegal)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  int          ack_prob, ready_prob, redir_prob, lat_min, lat_max, ready_mode;
  int          force_ready = -1;
  bit          force_redir = 0;
  logic [63:0] force_pc;

  // reference model state
  logic [63:0] exp_pc, exp_req, pend_addr, last_acc, prev_addr;
  bit          pend_valid, prev_hold, prev_redir;
  int          pend_delay, cyc, acc_count, pop_count;
  bit          s_req, s_valid;
  logic [63:0] s_addr, s_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h200: return 32'hF840_0000;
      64'h204: return 32'hFFFF_FFFF;
      64'h208: return 32'h1400_0003;
      default: return (a[31:0] * 32'h9E37_79B1) + 32'h0123_4567 ^ a[63:32];
    endcase
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
`ifdef FETCH_OPCODE_CHECK_EN
    logic [10:0] op;
    op = w[31:21];
    return !((op == 11'b11111000010) || (op == 11'b11111000000) ||
             (op == 11'b10001011000) || (op == 11'b11001011000) ||
             (op == 11'b10001010000) || (op == 11'b10101010000) ||
             (op[10:3] == 8'b10110100) || (op[10:5] == 6'b000101));
`else
    return (w == 32'h1) && 1'b0;
`endif
  endfunction

  task automatic step();
    logic [31:0] w;
    bit          pend_before;
    @(negedge CLK);
    if (pend_valid && pend_delay == 0) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = mem_word(pend_addr);
    end else begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = $urandom;
    end
    imem.imem_ack = ($urandom_range(99) < ack_prob);
    if (force_ready >= 0)     inst_ready = (force_ready != 0);
    else if (ready_mode == 1) inst_ready = imem.imem_rvalid && inst_valid;
    else                      inst_ready = ($urandom_range(99) < ready_prob);
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = force_pc; force_redir = 0;
    end else if ($urandom_range(99) < redir_prob) begin
      redirect = 1'b1;
      case ($urandom_range(3))
        0: redirect_pc = {32'h0, $urandom} & ~64'h3;
        1: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        2: redirect_pc = 64'h200;
        default: redirect_pc = {$urandom, $urandom} & ~64'h3;
      endcase
    end else begin
      redirect = 1'b0;
    end
    #1;
    s_req = imem.imem_req; s_addr = imem.imem_addr; s_valid = inst_valid; s_pc = inst_pc;
    if (prev_hold && !prev_redir) begin
      check("req_held", s_req, 1);
      check("addr_held", s_addr, prev_addr);
    end
    if (inst_valid && inst_ready) begin
      w = mem_word(exp_pc);
      check("inst_pc", inst_pc, exp_pc);
      check("inst", inst, w);
      check("opcode", Opcode, w[31:21]);
      check("illegal", illegal, exp_illegal(w));
      exp_pc += 64'd4;
      pop_count++;
    end else if (!inst_valid) begin
      check("illegal_novalid", illegal, 0);
    end
    pend_before = pend_valid;
    if (imem.imem_rvalid) pend_valid = 0;
    else if (pend_valid) pend_delay--;
    if (s_req && imem.imem_ack) begin
      check("one_outstanding", pend_before, 0);
      check("req_addr", s_addr, exp_req);
      exp_req   += 64'd4;
      pend_valid = 1;
      pend_addr  = s_addr;
      pend_delay = $urandom_range(lat_max - 1, lat_min - 1);
      acc_count++;
      last_acc   = s_addr;
    end
    if (redirect) begin
      exp_pc  = redirect_pc;
      exp_req = redirect_pc;
    end
    prev_hold  = s_req && !imem.imem_ack;
    prev_addr  = s_addr;
    prev_redir = redirect;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b1; imem.imem_ack = 0; imem.imem_rvalid = 0; redirect = 0; inst_ready = 0;
    @(posedge CLK);
    #1;
    check("rst_req", imem.imem_req, 0);
    check("rst_addr", imem.imem_addr, RESET_PC);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_opcode", Opcode, 0);
    check("rst_illegal", illegal, 0);
    Reset = 1'b0;
    pend_valid = 0; exp_pc = RESET_PC; exp_req = RESET_PC;
    prev_hold = 0; prev_redir = 0; cyc = 0; acc_count = 0; force_ready = -1; ready_mode = 0;
  endtask

  task automatic knobs(input int a, input int lmin, input int lmax, input int r, input int rd);
    ack_prob = a; lat_min = lmin; lat_max = lmax; ready_prob = r; redir_prob = rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    imem.imem_ack = 0; imem.imem_rvalid = 0; imem.imem_rdata = '0;
    pop_count = 0; ready_mode = 0;

    // Latency from reset with zero-wait memory
    knobs(100, 1, 1, 100, 0);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 1) begin
        check("t1_req_c1", s_req, 1);
        check("t1_addr_c1", s_addr, RESET_PC);
      end
      check($sformatf("t1_valid_c%0d", c), s_valid, (c == 3));
      if (c == 3) check("t1_pc_c3", s_pc, RESET_PC);
    end
    p0 = pop_count;
    repeat (20) step();
    check("t1_progress", (pop_count - p0) >= 8, 1);

    // Back-pressure: fill, hold, one slot freed
    knobs(100, 1, 1, 0, 0);
    do_reset();
    force_ready = 0;
    repeat (12) step();
    check("t2_acc", acc_count, 2);
    check("t2_hold_req", s_req, 0);
    force_ready = 1; step(); force_ready = 0;
    repeat (10) step();
    check("t2_acc_after", acc_count, 3);
    check("t2_last_addr", last_acc, 64'h8);
    check("t2_full_valid", s_valid, 1);

    // Redirect while the addr-4 response is in flight
    knobs(100, 3, 3, 100, 0);
    do_reset();
    force_ready = 0;
    n = 0;
    while (acc_count < 2 && n < 30) begin step(); n++; end
    check("t3_reach_wait", acc_count, 2);
    force_redir = 1; force_pc = 64'h100;
    step();
    step();
    check("t3_flushed", s_valid, 0);
    force_ready = -1;
    n = 0;
    while (acc_count < 3 && n < 40) begin step(); n++; end
    check("t3_next_req", last_acc, 64'h100);
    p0 = pop_count; n = 0;
    while (pop_count == p0 && n < 40) begin step(); n++; end
    check("t3_pop_seen", pop_count > p0, 1);

    // Simultaneous push and pop with a single held entry
    knobs(100, 1, 1, 0, 0);
    do_reset();
    ready_mode = 1;
    repeat (4) step();
    p0 = pop_count;
    for (int c = 0; c < 10; c++) begin
      step();
      check("t4_valid", s_valid, 1);
    end
    check("t4_pops", pop_count - p0, 5);
    ready_mode = 0;

    // Opcode legality words at 0x200..0x208
    knobs(100, 1, 2, 100, 0);
    do_reset();
    force_redir = 1; force_pc = 64'h200;
    p0 = pop_count; n = 0;
    while (pop_count < p0 + 4 && n < 60) begin step(); n++; end
    check("t5_pops", pop_count >= p0 + 4, 1);

    // Reset while in WAIT
    knobs(100, 4, 4, 100, 0);
    do_reset();
    n = 0;
    while (acc_count < 1 && n < 20) begin step(); n++; end
    step();
    do_reset();
    n = 0;
    while (acc_count < 1 && n < 20) begin step(); n++; end
    check("t6_refetch", last_acc, RESET_PC);

    // Randomized traffic with redirects and wrap-around targets
    knobs(100, 1, 1, 100, 0);
    do_reset();
    p0 = pop_count;
    for (int k = 0; k < 15; k++) begin
      knobs($urandom_range(100, 30), 1, $urandom_range(5, 1), $urandom_range(100, 0),
            $urandom_range(8, 0));
      repeat (200) step();
    end
    knobs(100, 1, 1, 100, 0);
    repeat (20) step();
    check("rand_progress", (pop_count - p0) > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
